// File: rtl/conv_pe_feeder.sv
// conv_pe_feeder: transmit side of the conv_pe input protocol.
// Preloads one filter set, pulses change_filter, then streams a zero-padded
// 3-row IFM window per pixel with edge flags, data_run and a lagged cal_start.
module conv_pe_feeder #(
    parameter int K           = 3,
    parameter int IFM_DW      = 32,
    parameter int FILTER_DW   = 72,
    parameter int Tout        = 4,
    parameter int LOAD_CYCLES = 4,
    parameter int W_SIZE      = 9,
    parameter int FLAG_DELAY  = 2,
    parameter int CAL_LAG     = 3,
    localparam int LIW        = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [W_SIZE-1:0]         cfg_width,
    input  logic [W_SIZE-1:0]         cfg_height,
    output logic                      busy,
    output logic                      done,
    output logic                      flt_rd_en,
    output logic [LIW-1:0]            flt_rd_addr,
    input  logic [Tout*FILTER_DW-1:0] flt_rd_data,
    output logic                      ifm_rd_en,
    output logic [W_SIZE-1:0]         ifm_rd_row,
    output logic [W_SIZE-1:0]         ifm_rd_col,
    input  logic [K*IFM_DW-1:0]       ifm_rd_data,
    output logic                      o_load_filter,
    output logic [LIW-1:0]            o_load_idx,
    output logic [Tout*FILTER_DW-1:0] o_filter_flat,
    output logic                      o_change_filter,
    output logic                      o_data_run,
    output logic                      o_cal_start,
    output logic [K*IFM_DW-1:0]       o_ifm_flat,
    output logic                      o_is_first_row,
    output logic                      o_is_last_row,
    output logic                      o_is_first_col,
    output logic                      o_is_last_col
);

    // Drain must outlast the 2-stage IFM path plus the longer of the flag/cal pipes.
    localparam int DRAIN_LEN = 2 + ((FLAG_DELAY > CAL_LAG) ? FLAG_DELAY : CAL_LAG);
    localparam int DCW       = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_CHANGE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [W_SIZE-1:0] width_q;
    logic [W_SIZE-1:0] height_q;
    logic              zero_q;
    logic [DCW-1:0]    drain_cnt;

    logic              s1_valid;
    logic [W_SIZE-1:0] s1_row;
    logic [W_SIZE-1:0] s1_col;
    logic [K*IFM_DW-1:0] masked;
    logic [3:0]        beat_flags;
    logic [3:0]        flag_pipe [FLAG_DELAY+1];
    logic [CAL_LAG-1:0] cal_pipe;

    // Frame sequencer: filter load, filter swap, raster request generation and drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            flt_rd_en       <= 1'b0;
            flt_rd_addr     <= '0;
            ifm_rd_en       <= 1'b0;
            ifm_rd_row      <= '0;
            ifm_rd_col      <= '0;
            width_q         <= '0;
            height_q        <= '0;
            zero_q          <= 1'b0;
            drain_cnt       <= '0;
            o_change_filter <= 1'b0;
        end else begin
            done            <= 1'b0;
            o_change_filter <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        width_q     <= cfg_width;
                        height_q    <= cfg_height;
                        zero_q      <= (cfg_width == '0) || (cfg_height == '0);
                        busy        <= 1'b1;
                        flt_rd_en   <= 1'b1;
                        flt_rd_addr <= '0;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (flt_rd_addr == LIW'(LOAD_CYCLES - 1)) begin
                        flt_rd_en   <= 1'b0;
                        flt_rd_addr <= '0;
                        state       <= S_GAP;
                    end else begin
                        flt_rd_addr <= flt_rd_addr + 1'b1;
                    end
                end
                S_GAP: begin
                    state <= S_CHANGE;
                end
                S_CHANGE: begin
                    o_change_filter <= 1'b1;
                    if (zero_q) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                    end else begin
                        ifm_rd_en  <= 1'b1;
                        ifm_rd_row <= '0;
                        ifm_rd_col <= '0;
                        state      <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (ifm_rd_col == width_q - 1'b1) begin
                        ifm_rd_col <= '0;
                        if (ifm_rd_row == height_q - 1'b1) begin
                            ifm_rd_en  <= 1'b0;
                            ifm_rd_row <= '0;
                            drain_cnt  <= DCW'(DRAIN_LEN - 1);
                            state      <= S_DRAIN;
                        end else begin
                            ifm_rd_row <= ifm_rd_row + 1'b1;
                        end
                    end else begin
                        ifm_rd_col <= ifm_rd_col + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Filter beat register; the buffer's data arrives alongside the registered strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_load_filter <= 1'b0;
            o_load_idx    <= '0;
        end else begin
            o_load_filter <= flt_rd_en;
            o_load_idx    <= flt_rd_addr;
        end
    end

    assign o_filter_flat = o_load_filter ? flt_rd_data : '0;

    // Zero the neighbour rows that fall outside the frame for the pixel now returning.
    always_comb begin
        masked = ifm_rd_data;
        if (s1_row == '0) begin
            masked[IFM_DW-1:0] = '0;
        end
        if (s1_row == height_q - 1'b1) begin
            masked[K*IFM_DW-1 -: IFM_DW] = '0;
        end
    end

    assign beat_flags = {s1_row == '0, s1_row == height_q - 1'b1,
                         s1_col == '0, s1_col == width_q - 1'b1};

    // IFM path: request tag capture, then masked window register, flag and cal pipes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_row     <= '0;
            s1_col     <= '0;
            o_data_run <= 1'b0;
            o_ifm_flat <= '0;
            for (int i = 0; i <= FLAG_DELAY; i++) begin
                flag_pipe[i] <= '0;
            end
            cal_pipe   <= '0;
        end else begin
            s1_valid     <= ifm_rd_en;
            s1_row       <= ifm_rd_row;
            s1_col       <= ifm_rd_col;
            o_data_run   <= s1_valid;
            o_ifm_flat   <= s1_valid ? masked : '0;
            flag_pipe[0] <= s1_valid ? beat_flags : 4'b0000;
            for (int i = 1; i <= FLAG_DELAY; i++) begin
                flag_pipe[i] <= flag_pipe[i-1];
            end
            cal_pipe[0]  <= o_data_run;
            for (int i = 1; i < CAL_LAG; i++) begin
                cal_pipe[i] <= cal_pipe[i-1];
            end
        end
    end

    assign {o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col} = flag_pipe[FLAG_DELAY];
    assign o_cal_start = cal_pipe[CAL_LAG-1];

endmodule

// File: tb/tb_conv_pe_feeder.sv
// tb_conv_pe_feeder: drives whole frames into conv_pe_feeder with random filter and
// pixel contents, and checks every output cycle by cycle against a timeline model.
module tb_conv_pe_feeder;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [8:0]    cfg_width;
    logic [8:0]    cfg_height;
    logic          busy;
    logic          done;
    logic          flt_rd_en;
    logic [1:0]    flt_rd_addr;
    logic [287:0]  flt_rd_data = '0;
    logic          ifm_rd_en;
    logic [8:0]    ifm_rd_row;
    logic [8:0]    ifm_rd_col;
    logic [95:0]   ifm_rd_data = '0;
    logic          o_load_filter;
    logic [1:0]    o_load_idx;
    logic [287:0]  o_filter_flat;
    logic          o_change_filter;
    logic          o_data_run;
    logic          o_cal_start;
    logic [95:0]   o_ifm_flat;
    logic          o_is_first_row;
    logic          o_is_last_row;
    logic          o_is_first_col;
    logic          o_is_last_col;

    int            assertCount = 0;
    int            failCount = 0;
    logic [287:0]  flt_mem [0:3];
    logic [31:0]   pix [0:511];
    logic [31:0]   junk = 32'h1;
    int            cur_w = 0;
    int            cur_h = 0;

    conv_pe_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .busy            (busy),
        .done            (done),
        .flt_rd_en       (flt_rd_en),
        .flt_rd_addr     (flt_rd_addr),
        .flt_rd_data     (flt_rd_data),
        .ifm_rd_en       (ifm_rd_en),
        .ifm_rd_row      (ifm_rd_row),
        .ifm_rd_col      (ifm_rd_col),
        .ifm_rd_data     (ifm_rd_data),
        .o_load_filter   (o_load_filter),
        .o_load_idx      (o_load_idx),
        .o_filter_flat   (o_filter_flat),
        .o_change_filter (o_change_filter),
        .o_data_run      (o_data_run),
        .o_cal_start     (o_cal_start),
        .o_ifm_flat      (o_ifm_flat),
        .o_is_first_row  (o_is_first_row),
        .o_is_last_row   (o_is_last_row),
        .o_is_first_col  (o_is_first_col),
        .o_is_last_col   (o_is_last_col)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Line buffer word lookup; rows or columns outside the frame return nonzero junk.
    function automatic logic [31:0] lbWord(int r, int c);
        if (r < 0 || r >= cur_h || c < 0 || c >= cur_w) return junk;
        return pix[9'(r * cur_w + c)];
    endfunction

    // Filter buffer model: synchronous read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (flt_rd_en) flt_rd_data <= flt_mem[flt_rd_addr];
    end

    // Line buffer model: synchronous read of {row r+1, row r, row r-1} at column c.
    always @(posedge clk) begin
        if (ifm_rd_en) begin
            ifm_rd_data <= {lbWord(int'(ifm_rd_row) + 1, int'(ifm_rd_col)),
                            lbWord(int'(ifm_rd_row), int'(ifm_rd_col)),
                            lbWord(int'(ifm_rd_row) - 1, int'(ifm_rd_col))};
        end
    end

    // Expected padded window for pixel (r,c) of a w x h frame.
    function automatic logic [95:0] expFlat(int r, int c, int w, int h);
        logic [31:0] top;
        logic [31:0] mid;
        logic [31:0] bot;
        top = (r == 0) ? 32'd0 : pix[9'((r - 1) * w + c)];
        mid = pix[9'(r * w + c)];
        bot = (r == h - 1) ? 32'd0 : pix[9'((r + 1) * w + c)];
        return {bot, mid, top};
    endfunction

    task automatic checkOutput(input string name, input int n,
                               input logic [511:0] observed, input logic [511:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s @%0d: observed %0h expected %0h", name, n, observed, expected);
        end
    endtask

    task automatic checkReset(input int n);
        checkOutput("reset_outputs", n,
            512'({busy, done, flt_rd_en, flt_rd_addr, ifm_rd_en, ifm_rd_row, ifm_rd_col,
                  o_load_filter, o_load_idx, o_filter_flat, o_change_filter, o_data_run,
                  o_cal_start, o_ifm_flat, o_is_first_row, o_is_last_row,
                  o_is_first_col, o_is_last_col}),
            512'(0));
    endtask

    // Fill buffers, set the frame size and pulse start across one rising edge.
    task automatic applyStimulus(input int w, input int h, input bit pattern);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 9; j++) begin
                flt_mem[i][j*32 +: 32] = pattern ? {4{8'(i + 1)}} : $urandom;
            end
        end
        for (int i = 0; i < w * h; i++) begin
            pix[9'(i)] = $urandom;
        end
        junk       = $urandom | 32'h1;
        cur_w      = w;
        cur_h      = h;
        cfg_width  = 9'(w);
        cfg_height = 9'(h);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One frame checked cycle by cycle; n counts cycles after the accepted start edge.
    task automatic runFrame(input int w, input int h, input bit pattern);
        int wh;
        int done_n;
        int total;
        int p;
        bit zero;
        logic [3:0] e_flags;
        $display("[TB] frame W=%0d H=%0d", w, h);
        applyStimulus(w, h, pattern);
        zero   = (w == 0) || (h == 0);
        wh     = w * h;
        done_n = zero ? 8 : 12 + wh;
        total  = done_n + 2;
        for (int n = 1; n <= total; n++) begin
            if (n > 1) @(negedge clk);
            start = (n == 2 || n == done_n);

            checkOutput("flt_rd_en", n, 512'(flt_rd_en), 512'(n >= 1 && n <= 4));
            if (n >= 1 && n <= 4) checkOutput("flt_rd_addr", n, 512'(flt_rd_addr), 512'(n - 1));

            checkOutput("load_filter", n, 512'(o_load_filter), 512'(n >= 2 && n <= 5));
            if (n >= 2 && n <= 5) checkOutput("load_idx", n, 512'(o_load_idx), 512'(n - 2));
            checkOutput("filter_flat", n, 512'(o_filter_flat),
                        (n >= 2 && n <= 5) ? 512'(flt_mem[2'(n - 2)]) : 512'(0));

            checkOutput("change_filter", n, 512'(o_change_filter), 512'(n == 7));

            p = n - 7;
            checkOutput("ifm_rd_en", n, 512'(ifm_rd_en), 512'(!zero && p >= 0 && p < wh));
            if (!zero && p >= 0 && p < wh) begin
                checkOutput("ifm_rd_row", n, 512'(ifm_rd_row), 512'(p / w));
                checkOutput("ifm_rd_col", n, 512'(ifm_rd_col), 512'(p % w));
            end

            p = n - 9;
            checkOutput("data_run", n, 512'(o_data_run), 512'(!zero && p >= 0 && p < wh));
            if (!zero && p >= 0 && p < wh) begin
                checkOutput("ifm_flat", n, 512'(o_ifm_flat), 512'(expFlat(p / w, p % w, w, h)));
            end

            p = n - 11;
            e_flags = 4'b0000;
            if (!zero && p >= 0 && p < wh) begin
                e_flags = {(p / w) == 0, (p / w) == h - 1, (p % w) == 0, (p % w) == w - 1};
            end
            checkOutput("edge_flags", n,
                        512'({o_is_first_row, o_is_last_row, o_is_first_col, o_is_last_col}),
                        512'(e_flags));

            p = n - 12;
            checkOutput("cal_start", n, 512'(o_cal_start), 512'(!zero && p >= 0 && p < wh));

            checkOutput("done", n, 512'(done), 512'(n == done_n));
            checkOutput("busy", n, 512'(busy), 512'(n <= done_n));
        end
        start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cfg_width  = '0;
        cfg_height = '0;
        for (int i = 0; i < 4; i++) flt_mem[i] = '0;
        repeat (3) @(negedge clk);
        checkReset(0);
        rst = 1'b0;
        @(negedge clk);

        runFrame(16, 3, 1'b1);
        runFrame(4, 1, 1'b0);
        runFrame(0, 5, 1'b0);
        runFrame(6, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            runFrame(int'($urandom_range(1, 12)), int'($urandom_range(1, 6)), 1'b0);
        end

        $display("[TB] reset in the middle of a streaming frame");
        applyStimulus(8, 4, 1'b0);
        for (int i = 0; i < 40 && !ifm_rd_en; i++) @(negedge clk);
        checkOutput("stream_reached", 0, 512'(ifm_rd_en), 512'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkReset(1);
        @(negedge clk);
        checkReset(2);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("post_reset_idle", i,
                        512'({busy, done, flt_rd_en, ifm_rd_en, o_data_run}), 512'(0));
        end
        runFrame(5, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
